// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported, byte-addressed 16-bit memory between the fetch
//   stage (if_*) and the memory stage (dm_*). One transaction is outstanding
//   at a time. A grant is given combinationally in IDLE, the memory port is
//   driven for LATENCY cycles, and a one-cycle rvalid pulse returns read data
//   or acknowledges a write. Data requests win, except that a pending fetch is
//   forced through after STARVE_MAX consecutive data grants.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   if_req/if_addr            fetch request and byte address
//   if_gnt                    fetch granted this cycle
//   if_rvalid/if_rdata/if_err fetch response pulse, held data, odd-address flag
//   dm_req/dm_wr/dm_addr/dm_wdata  data request
//   dm_gnt                    data granted this cycle
//   dm_rvalid/dm_rdata        data response pulse (read data or write done)
//   mem_en/mem_wr/mem_addr/mem_wdata  memory port
//   mem_rdata                 memory read data (combinational from mem_addr)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int LATENCY    = 1,   // 1..15
    parameter int STARVE_MAX = 2    // 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [15:0] if_rdata,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [15:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [3:0] CNT_LOAD   = 4'(LATENCY - 1);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Attributes of the transaction in flight; address and write data live
    // directly in the memory-port registers.
    typedef struct packed {
        logic wr;        // data write
        logic owner_dm;  // 1 = data port, 0 = fetch port
        logic err;       // odd fetch, memory never touched
    } txn_t;

    state_t      state, state_nxt;
    txn_t        cur;
    logic [3:0]  cnt;
    logic [2:0]  starve_cnt;
    logic [15:0] if_rdata_q, dm_rdata_q;
    logic [15:0] mem_addr_q, mem_wdata_q;

    logic fetch_wins, gnt_if, gnt_dm, grant, odd_fetch, last_beat;

    // ------------------------------------------------------------------
    // Arbitration. Grants are gated by rst so they read 0 during reset
    // even while a requester holds req high.
    // ------------------------------------------------------------------
    always_comb begin
        fetch_wins = if_req && (!dm_req || (starve_cnt == STARVE_LIM));
        gnt_if     = rst && (state == IDLE) && fetch_wins;
        gnt_dm     = rst && (state == IDLE) && dm_req && !fetch_wins;
        grant      = gnt_if || gnt_dm;
        odd_fetch  = gnt_if && if_addr[0];
        last_beat  = (state == ACCESS) && (cnt == '0);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = odd_fetch ? RESP : ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture, access counter, starvation counter, read data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur         <= '0;
            cnt         <= '0;
            starve_cnt  <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (grant) begin
                cur.wr       <= gnt_dm && dm_wr;
                cur.owner_dm <= gnt_dm;
                cur.err      <= odd_fetch;
                cnt          <= CNT_LOAD;
                // An odd fetch never reaches the memory, so the port keeps
                // showing the previous access.
                if (!odd_fetch) begin
                    mem_addr_q  <= gnt_dm ? dm_addr  : if_addr;
                    mem_wdata_q <= gnt_dm ? dm_wdata : '0;
                end
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - 4'd1;
            end

            // Only data grants made under fetch pressure accumulate.
            if (gnt_if)      starve_cnt <= '0;
            else if (gnt_dm) starve_cnt <= if_req ? starve_cnt + 3'd1 : '0;

            if (last_beat && !cur.wr) begin
                if (cur.owner_dm) dm_rdata_q <= mem_rdata;
                else              if_rdata_q <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Everything state-derived is 0 in reset because state is
    // forced to IDLE and the registers are cleared asynchronously.
    // ------------------------------------------------------------------
    always_comb begin
        if_gnt    = gnt_if;
        dm_gnt    = gnt_dm;
        if_rvalid = (state == RESP) && !cur.owner_dm;
        if_err    = (state == RESP) && !cur.owner_dm && cur.err;
        dm_rvalid = (state == RESP) && cur.owner_dm;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
        mem_en    = (state == ACCESS);
        mem_wr    = (state == ACCESS) && cur.wr;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed transaction table, contention / withdrawal / reset sequences, then
//   a randomized phase checked every cycle against a time-based reference
//   model (grant cycle, busy-until cycle, response cycle, shadow memory).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int LAT  = 3;
    localparam int SMAX = 2;

    logic        clk, rst;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [15:0] if_addr, if_rdata;
    logic        dm_req, dm_wr, dm_gnt, dm_rvalid;
    logic [15:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 256 words, word index = addr[8:1]
    logic [15:0] mem [0:255];
    logic        mem_ready;

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 257) ^ 16'hA5A5;
    endfunction

    assign mem_rdata = mem[mem_addr[8:1]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_en && mem_wr) begin
            mem[mem_addr[8:1]] <= mem_wdata;
        end
    end

    int n_cmp, n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_dm;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;  // owner's rdata seen with rvalid
        logic        exp_err;
    } vec_t;

    // Issue one transaction from IDLE; returns at posedge+1 of the cycle after
    // the response, i.e. the first cycle a new grant is possible.
    task automatic do_txn(input vec_t v, input string tag);
        int resp_at, en_cnt, wr_cnt;
        resp_at = -1; en_cnt = 0; wr_cnt = 0;
        if (v.is_dm) begin
            dm_req = 1'b1; dm_wr = v.wr; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        @(negedge clk);
        chk({tag, ".gnt"},   v.is_dm ? dm_gnt : if_gnt, 1);
        chk({tag, ".other"}, v.is_dm ? if_gnt : dm_gnt, 0);
        tick();
        dm_req = 1'b0; if_req = 1'b0;
        for (int k = 1; k <= LAT + 3 && resp_at < 0; k++) begin
            @(negedge clk);
            if (mem_en) en_cnt++;
            if (mem_wr) wr_cnt++;
            if (dm_rvalid || if_rvalid) begin
                resp_at = k;
                chk({tag, ".owner"}, dm_rvalid, v.is_dm);
                chk({tag, ".rdata"}, v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
                chk({tag, ".err"}, if_err, v.exp_err);
            end
            if (resp_at < 0) tick();
        end
        chk({tag, ".lat"}, resp_at, v.exp_err ? 1 : LAT + 1);
        chk({tag, ".en_cycles"}, en_cnt, v.exp_err ? 0 : LAT);
        chk({tag, ".wr_cycles"}, wr_cnt, v.wr ? LAT : 0);
        tick();
    endtask

    vec_t vecs[10];
    vec_t v;

    // Reference model state for the random phase
    logic [15:0] ref_mem [0:255];
    int          next_free, resp_cyc, acc_lo, acc_hi, starve;
    logic        resp_dm, resp_err, resp_wr, acc_wr;
    logic [15:0] resp_data, acc_addr, acc_wdata, exp_if, exp_dm;

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b0; mem_ready = 1'b0;
        if_req = 1'b1; if_addr = 16'h0002;
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0004; dm_wdata = 16'hFFFF;

        // ---------------- reset state, requests held high ----------------
        tick(); tick();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rst.if_gnt", if_gnt, 0);
        chk("rst.dm_gnt", dm_gnt, 0);
        chk("rst.if_rvalid", if_rvalid, 0);
        chk("rst.dm_rvalid", dm_rvalid, 0);
        chk("rst.if_err", if_err, 0);
        chk("rst.mem_en", mem_en, 0);
        chk("rst.mem_wr", mem_wr, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.if_rdata", if_rdata, 0);
        chk("rst.dm_rdata", dm_rdata, 0);
        tick();
        if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // ---------------- directed transaction table ----------------
        vecs[0] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hADAD, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'h1234, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'hADAD, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 16'h01FE, 16'h0000, 16'h5A5A, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h2525, 1'b0};
        for (int i = 0; i < 10; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // ---------------- contention: D D F D D F every LAT+2 ----------------
        begin
            logic [5:0] pat_dm;
            int ng, last;
            pat_dm = 6'b011011;
            ng = 0; last = -1;
            dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0000;
            if_req = 1'b1; if_addr = 16'h0002;
            for (int c = 0; c < 6 * (LAT + 2) + 4 && ng < 6; c++) begin
                @(negedge clk);
                if (if_gnt || dm_gnt) begin
                    chk($sformatf("cont.owner%0d", ng), dm_gnt, pat_dm[ng]);
                    chk("cont.single", if_gnt & dm_gnt, 0);
                    chk("cont.gap", c - last, (last < 0) ? c + 1 : LAT + 2);
                    last = c;
                    ng++;
                end
                tick();
            end
            dm_req = 1'b0; if_req = 1'b0;
            chk("cont.count", ng, 6);
            repeat (LAT + 2) tick();
        end

        // ---------------- withdrawal during ACCESS ----------------
        begin
            int gnts, rvs;
            gnts = 0; rvs = 0;
            dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
            @(negedge clk);
            chk("wd.gnt0", dm_gnt, 1);
            tick();                 // cycle 1: request stays up, no grant
            for (int c = 1; c <= LAT + 3; c++) begin
                if (c == 2) dm_req = 1'b0;
                @(negedge clk);
                if (dm_gnt || if_gnt) gnts++;
                if (dm_rvalid) begin
                    rvs++;
                    chk("wd.rv_cycle", c, LAT + 1);
                end
                tick();
            end
            chk("wd.no_gnt", gnts, 0);
            chk("wd.one_rvalid", rvs, 1);
            chk("wd.mem_en_idle", mem_en, 0);
        end

        // ---------------- reset during a write ----------------
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'h5555;
        @(negedge clk);
        chk("rw.gnt", dm_gnt, 1);
        tick(); tick();
        chk("rw.mem_wr_before", mem_wr, 1);
        rst = 1'b0;
        #1;
        chk("rw.mem_en", mem_en, 0);
        chk("rw.mem_wr", mem_wr, 0);
        chk("rw.gnt_gated", dm_gnt, 0);
        dm_req = 1'b0; dm_wr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rw.no_dm_rvalid", dm_rvalid, 0);
            chk("rw.no_if_rvalid", if_rvalid, 0);
            chk("rw.dm_rdata", dm_rdata, 0);
            tick();
        end
        rst = 1'b1;
        v = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0};
        do_txn(v, "after_rst");

        // ---------------- randomized phase with reference model ----------------
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        next_free = 0; resp_cyc = -1; acc_lo = -1; acc_hi = -2; starve = 0;
        resp_dm = 1'b0; resp_err = 1'b0; resp_wr = 1'b0; acc_wr = 1'b0;
        resp_data = '0; acc_addr = '0; acc_wdata = '0;
        exp_if = 16'h1234; exp_dm = 16'h0000;
        for (int c = 0; c < 1500; c++) begin
            logic eg_if, eg_dm, fw;
            if_req   = ($urandom_range(0, 2) != 0);
            if_addr  = 16'($urandom);
            dm_req   = ($urandom_range(0, 1) != 0);
            dm_wr    = ($urandom_range(0, 2) == 0);
            dm_addr  = 16'($urandom);
            dm_wdata = 16'($urandom);
            @(negedge clk);
            if (c == resp_cyc && !resp_wr && !resp_err) begin
                if (resp_dm) exp_dm = resp_data;
                else         exp_if = resp_data;
            end
            eg_if = 1'b0; eg_dm = 1'b0;
            if (c >= next_free && (if_req || dm_req)) begin
                fw    = if_req && (!dm_req || starve == SMAX);
                eg_if = fw;
                eg_dm = !fw;
                if (fw) starve = 0;
                else    starve = if_req ? starve + 1 : 0;
                resp_dm  = !fw;
                resp_wr  = !fw && dm_wr;
                resp_err = fw && if_addr[0];
                if (resp_err) begin
                    resp_cyc  = c + 1;
                    next_free = c + 2;
                end else begin
                    acc_addr  = fw ? if_addr : dm_addr;
                    acc_wdata = dm_wdata;
                    acc_wr    = resp_wr;
                    acc_lo    = c + 1;
                    acc_hi    = c + LAT;
                    resp_cyc  = c + LAT + 1;
                    next_free = c + LAT + 2;
                    if (resp_wr) ref_mem[acc_addr[8:1]] = acc_wdata;
                    else         resp_data = ref_mem[acc_addr[8:1]];
                end
            end
            chk("rnd.if_gnt", if_gnt, eg_if);
            chk("rnd.dm_gnt", dm_gnt, eg_dm);
            chk("rnd.if_rvalid", if_rvalid, c == resp_cyc && !resp_dm);
            chk("rnd.dm_rvalid", dm_rvalid, c == resp_cyc && resp_dm);
            chk("rnd.if_err", if_err, c == resp_cyc && !resp_dm && resp_err);
            chk("rnd.mem_en", mem_en, c >= acc_lo && c <= acc_hi);
            chk("rnd.mem_wr", mem_wr, c >= acc_lo && c <= acc_hi && acc_wr);
            if (c >= acc_lo && c <= acc_hi) begin
                chk("rnd.mem_addr", mem_addr, acc_addr);
                if (acc_wr) chk("rnd.mem_wdata", mem_wdata, acc_wdata);
            end
            chk("rnd.if_rdata", if_rdata, exp_if);
            chk("rnd.dm_rdata", dm_rdata, exp_dm);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares one unified 16-bit, byte-addressable, single-ported memory between the fetch stage and the memory stage. It accepts one request at a time through a request/grant handshake and drives the memory port for a parameterised number of access cycles. It returns read data or a write acknowledge through a one-cycle valid pulse. Data accesses have priority, and a starvation guard bounds how long a pending fetch can wait.

## Interface
- LATENCY, 1: memory access cycles per transaction (1..15); mem_rdata is sampled at the end of the last one.
- STARVE_MAX, 2: consecutive data grants allowed while if_req is pending before fetch is forced through (1..7).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low: rst=0 clears all state immediately.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  16  fetch byte address.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  16  fetched instruction word.
- if_err  out  1  qualifies if_rvalid; odd fetch address.
- dm_req  in  1  data request; held until dm_gnt.
- dm_wr  in  1  1 = write, 0 = read.
- dm_addr  in  16  data byte address.
- dm_wdata  in  16  write data.
- dm_gnt  out  1  data granted this cycle.
- dm_rvalid  out  1  one-cycle pulse; read data valid, or write done.
- dm_rdata  out  16  read data.
- mem_en  out  1  memory access active.
- mem_wr  out  1  memory write enable.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data; combinational from mem_addr.

## Operation
- FSM states: IDLE, ACCESS, RESP. One transaction is outstanding at most.
- **IDLE:**
  - If any request is present, grant exactly one requester combinationally (gnt is high in the same cycle as its req).
  - Capture addr, wr, wdata and the owner on that edge, load the access counter with LATENCY-1, and go to ACCESS.
  - With no request, stay in IDLE.
- **Priority:**
  - dm_req beats if_req.
  - starve_cnt counts data grants made while if_req=1. When starve_cnt==STARVE_MAX and if_req=1, fetch wins.
  - starve_cnt clears on any fetch grant and on any grant made while if_req=0.
- **ACCESS:**
  - mem_en=1; mem_addr, mem_wr and mem_wdata come from the captured registers.
  - mem_wr=1 only for a captured data write. Fetches are never writes.
  - Counter at 0: capture mem_rdata into the owner's rdata register on reads only, then go to RESP. Otherwise decrement.
  - A write is committed by the memory on the final ACCESS edge. mem_wr is high for LATENCY cycles; the memory must tolerate repeated identical writes.
- **RESP:**
  - The owner's rvalid=1 for exactly this cycle; go to IDLE.
  - No grants are made in ACCESS or RESP.
- **Fetch with if_addr[0]=1:**
  - Granted normally, but goes IDLE→RESP directly with mem_en never asserted.
  - if_err=1 with if_rvalid; if_rdata is unchanged.
- **Held registers:** if_rdata and dm_rdata hold their last captured value until the next read of the same port. A data write leaves dm_rdata unchanged.
- **Requester rules:**
  - req may drop before gnt; the request is withdrawn with no effect.
  - req held high after gnt is treated as a new request at the next IDLE.
- **Memory outputs outside ACCESS:** mem_en=0, mem_wr=0, and mem_addr, mem_wdata hold their last value.

## Timing
- **Reset values:** state=IDLE, starve_cnt=0, counter=0, and all captured registers 0. Every output is 0 while rst=0, including gnt, so it is gated by rst.
- **Read latency:** gnt in cycle N, ACCESS in N+1..N+LATENCY, rvalid and rdata in N+LATENCY+1.
- **Throughput:** the next grant is possible in N+LATENCY+2, so back-to-back transactions cost LATENCY+2 cycles each.
- **Odd fetch:** gnt in N, RESP with if_err in N+1.
- **Reset mid-transaction:** the transaction is dropped with no rvalid, and mem_wr falls immediately (asynchronously). A write in flight may or may not have reached memory.
- **Simultaneous if_req and dm_req in IDLE:** exactly one gnt; the other requester keeps waiting with gnt=0.

## Test plan
- **Single read, LATENCY=1:** dm_req, dm_wr=0, dm_addr=0x0010, memory holds 0xBEEF → dm_gnt in cycle 0, mem_en in cycle 1, dm_rvalid=1 and dm_rdata=0xBEEF in cycle 2, idle in cycle 3.
- **Write then read, LATENCY=3:**
  - Write 0x1234 to 0x0020, then read 0x0020.
  - Write: mem_wr high for 3 cycles, dm_rvalid in cycle 4, dm_rdata unchanged.
  - Read returns 0x1234; the second gnt is in cycle 5.
- **Contention, STARVE_MAX=2:** if_req and dm_req held continuously → grant order D, D, F, D, D, F, with one grant every 3 cycles at LATENCY=1.
- **Odd fetch:** if_addr=0x0003 → if_gnt in cycle 0, if_rvalid=1 and if_err=1 in cycle 1, mem_en never high.
- **Withdrawal and reset:**
  - dm_req drops before gnt while in ACCESS → no dm_gnt.
  - rst=0 during ACCESS of a write → mem_en and mem_wr go to 0 the same cycle, no rvalid, and the first request after reset release is granted in IDLE.
